// File: rtl/mult_issue_taint1bit.sv
// Issue stage for the taint-tracked sequential multiplier: operand-pair FIFO with
// per-field taint, a start/done handshake FSM and a sticky control-taint bit.
module mult_issue_taint1bit #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_valid_t,
  output logic                     in_ready,
  output logic                     in_ready_t,
  input  logic [WIDTH-1:0]         in_multiplier,
  input  logic                     in_multiplier_t,
  input  logic [WIDTH-1:0]         in_multiplicand,
  input  logic                     in_multiplicand_t,
  output logic                     start,
  output logic                     start_t,
  output logic [WIDTH-1:0]         multiplier,
  output logic                     multiplier_t,
  output logic [WIDTH-1:0]         multiplicand,
  output logic                     multiplicand_t,
  input  logic                     productDone,
  input  logic                     productDone_t,
  output logic                     busy,
  output logic                     busy_t,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [DEPTH-1:0] mem_at, mem_bt, mem_vt;

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pd_q_reg, pd_q_t_reg, ctrl_t_reg;

  logic push, pop, done, empty, head_vt, ctrl_t_next;

  assign in_ready = (count_reg != CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push     = in_valid && in_ready;
  assign done     = productDone && !pd_q_reg;
  assign pop      = (state_reg == S_WAIT) && done;

  // Storage has no reset: an empty FIFO masks the head outputs to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg]  <= in_multiplier;
      mem_b[wr_ptr_reg]  <= in_multiplicand;
      mem_at[wr_ptr_reg] <= in_multiplier_t;
      mem_bt[wr_ptr_reg] <= in_multiplicand_t;
      mem_vt[wr_ptr_reg] <= in_valid_t;
    end
  end

  always_comb begin
    multiplier     = '0;
    multiplicand   = '0;
    multiplier_t   = 1'b0;
    multiplicand_t = 1'b0;
    head_vt        = 1'b0;
    if (!empty) begin
      multiplier     = mem_a[rd_ptr_reg];
      multiplicand   = mem_b[rd_ptr_reg];
      multiplier_t   = mem_at[rd_ptr_reg];
      multiplicand_t = mem_bt[rd_ptr_reg];
      head_vt        = mem_vt[rd_ptr_reg];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!empty) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control taint latches until the block drains completely with nothing arriving.
  always_comb begin
    ctrl_t_next = ctrl_t_reg;
    if (push && in_valid_t)
      ctrl_t_next = 1'b1;
    if ((state_reg == S_WAIT) && (productDone_t || pd_q_t_reg))
      ctrl_t_next = 1'b1;
    if ((state_reg == S_IDLE) && empty && !push)
      ctrl_t_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      pd_q_reg   <= 1'b0;
      pd_q_t_reg <= 1'b0;
      ctrl_t_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pd_q_reg   <= productDone;
      pd_q_t_reg <= productDone_t;
      ctrl_t_reg <= ctrl_t_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
    end
  end

  assign start      = (state_reg == S_ISSUE);
  assign start_t    = start && (ctrl_t_reg || head_vt);
  assign in_ready_t = ctrl_t_reg;
  assign busy       = (state_reg != S_IDLE) || !empty;
  assign busy_t     = ctrl_t_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_mult_issue_taint1bit.sv
// Scoreboard bench for mult_issue_taint1bit: accepted pairs are queued and
// compared against the head operands at each start pulse.
module tb_mult_issue_taint1bit;

  localparam int WIDTH = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_valid_t = 1'b0;
  logic in_ready, in_ready_t;
  logic [WIDTH-1:0] in_multiplier = '0, in_multiplicand = '0;
  logic in_multiplier_t = 1'b0, in_multiplicand_t = 1'b0;
  logic start, start_t;
  logic [WIDTH-1:0] multiplier, multiplicand;
  logic multiplier_t, multiplicand_t;
  logic productDone = 1'b0, productDone_t = 1'b0;
  logic busy, busy_t;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  mult_issue_taint1bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_valid_t(in_valid_t),
    .in_ready(in_ready), .in_ready_t(in_ready_t),
    .in_multiplier(in_multiplier), .in_multiplier_t(in_multiplier_t),
    .in_multiplicand(in_multiplicand), .in_multiplicand_t(in_multiplicand_t),
    .start(start), .start_t(start_t),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .productDone(productDone), .productDone_t(productDone_t),
    .busy(busy), .busy_t(busy_t), .count(count)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic at;
    logic bt;
    logic st;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Every start pulse consumes the oldest outstanding accepted pair.
  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      check("start_one_cycle", WIDTH'(prev_start), '0);
      if (sb.size() == 0) begin
        check("spurious_start", 1, 0);
      end else begin
        e = sb.pop_front();
        check("issue_a", multiplier, e.a);
        check("issue_b", multiplicand, e.b);
        check("issue_a_t", WIDTH'(multiplier_t), WIDTH'(e.at));
        check("issue_b_t", WIDTH'(multiplicand_t), WIDTH'(e.bt));
        check("issue_start_t", WIDTH'(start_t), WIDTH'(e.st));
      end
    end
    prev_start = start;
  end

  task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic at, input logic bt, input logic vt, input logic st);
    logic accepted;
    in_valid = 1'b1; in_valid_t = vt;
    in_multiplier = a; in_multiplicand = b;
    in_multiplier_t = at; in_multiplicand_t = bt;
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      if (in_ready) begin
        @(posedge clk);
        sb.push_back('{a, b, at, bt, st});
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("push_accept", WIDTH'(accepted), 1);
    @(negedge clk);
    in_valid = 1'b0; in_valid_t = 1'b0;
  endtask

  task automatic wait_issue(input int target);
    for (int i = 0; i < 60 && start_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("issue_seen", WIDTH'(start_cnt >= target), 1);
  endtask

  task automatic pulse_done();
    @(negedge clk); productDone = 1'b1;
    @(negedge clk); productDone = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_count", WIDTH'(count), 0);
    check("rst_in_ready", WIDTH'(in_ready), 1);
    check("rst_in_ready_t", WIDTH'(in_ready_t), 0);
    check("rst_busy", WIDTH'(busy), 0);
    check("rst_busy_t", WIDTH'(busy_t), 0);
    check("rst_start", WIDTH'({start, start_t}), 0);
    check("rst_operands", multiplier | multiplicand, 0);

    // Single pair: start two cycles after acceptance, one cycle wide.
    push_pair(7, 6, 0, 0, 0, 0);
    check("lat_k1_start", WIDTH'(start), 0);
    @(negedge clk);
    check("lat_k2_start", WIDTH'(start), 1);
    @(negedge clk);
    check("lat_k3_start", WIDTH'(start), 0);
    pulse_done();
    check("single_count", WIDTH'(count), 0);
    check("single_busy", WIDTH'(busy), 0);

    // Fill to DEPTH with the multiplier stalled, then a fifth pair waits.
    for (int i = 0; i < 4; i++) push_pair(rnd(), rnd(), 0, 0, 0, 0);
    check("full_count", WIDTH'(count), 4);
    check("full_in_ready", WIDTH'(in_ready), 0);
    in_valid = 1'b1; in_multiplier = rnd(); in_multiplicand = rnd();
    repeat (3) begin
      @(negedge clk);
      check("held_off", WIDTH'(count), 4);
    end
    @(negedge clk); productDone = 1'b1;
    @(negedge clk); productDone = 1'b0;
    check("after_pop_count", WIDTH'(count), 3);
    check("after_pop_ready", WIDTH'(in_ready), 1);
    push_pair(in_multiplier, in_multiplicand, 0, 0, 0, 0);
    for (int j = 3; j <= 6; j++) begin
      wait_issue(j);
      pulse_done();
    end
    check("drain_count", WIDTH'(count), 0);

    // productDone already high on entry to WAIT must not pop.
    @(negedge clk); productDone = 1'b1;
    push_pair(rnd(), rnd(), 0, 0, 0, 0);
    wait_issue(7);
    repeat (3) begin
      @(negedge clk);
      check("pd_held_no_pop", WIDTH'(count), 1);
    end
    productDone = 1'b0;
    @(negedge clk);
    check("pd_low_no_pop", WIDTH'(count), 1);
    productDone = 1'b1;
    @(negedge clk);
    productDone = 1'b0;
    check("pd_rise_pop", WIDTH'(count), 0);

    // Operand taint only: passes through, control taint stays clean.
    push_pair(rnd(), rnd(), 1, 0, 0, 0);
    check("data_t_head", WIDTH'(multiplier_t), 1);
    check("data_t_in_ready_t", WIDTH'(in_ready_t), 0);
    wait_issue(8);
    pulse_done();

    // Tainted valid: control taint until idle and empty.
    push_pair(rnd(), rnd(), 0, 0, 1, 1);
    check("vt_in_ready_t", WIDTH'(in_ready_t), 1);
    check("vt_busy_t", WIDTH'(busy_t), 1);
    wait_issue(9);
    pulse_done();
    check("vt_still_set", WIDTH'(busy_t), 1);
    @(negedge clk);
    check("vt_clear_in_ready_t", WIDTH'(in_ready_t), 0);
    check("vt_clear_busy_t", WIDTH'(busy_t), 0);
    push_pair(rnd(), rnd(), 0, 0, 0, 0);
    wait_issue(10);
    pulse_done();

    // Reset in WAIT with three entries queued.
    for (int i = 0; i < 3; i++) push_pair(rnd(), rnd(), 0, 0, 0, 0);
    wait_issue(11);
    @(negedge clk);
    check("pre_rst_count", WIDTH'(count), 3);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", WIDTH'(count), 0);
    check("mid_rst_busy", WIDTH'({busy, busy_t}), 0);
    check("mid_rst_ready", WIDTH'({in_ready, in_ready_t}), 2);
    check("mid_rst_start", WIDTH'({start, start_t}), 0);
    check("mid_rst_operands", multiplier | multiplicand, 0);
    repeat (6) @(negedge clk);
    #1;
    check("mid_rst_no_start", WIDTH'(start_cnt), 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_issue_taint1bit.md
# mult_issue_taint1bit

Upstream issue stage for the 1-bit taint-tracked sequential multiplier. It buffers operand pairs in a small FIFO, with 1-bit taint per field. It presents the head pair to the multiplier, pulses `start`, and waits for `productDone` before issuing the next pair. Taint follows each operand pair through the FIFO. A sticky control-taint bit covers every handshake decision that tainted inputs have influenced.

## Interface
- `WIDTH`, 128, operand width; must match the multiplier's `WIDTH`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid` / `in_valid_t`  in  1 / 1  operand pair offered; its taint.
- `in_ready` / `in_ready_t`  out  1 / 1  FIFO not full; its taint.
- `in_multiplier` / `in_multiplier_t`  in  WIDTH / 1  operand A; its taint.
- `in_multiplicand` / `in_multiplicand_t`  in  WIDTH / 1  operand B; its taint.
- `start` / `start_t`  out  1 / 1  one-cycle issue pulse to the multiplier; its taint.
- `multiplier` / `multiplier_t`  out  WIDTH / 1  head operand A; its taint.
- `multiplicand` / `multiplicand_t`  out  WIDTH / 1  head operand B; its taint.
- `productDone` / `productDone_t`  in  1 / 1  completion from the multiplier; its taint.
- `busy` / `busy_t`  out  1 / 1  state ≠ IDLE or FIFO non-empty; its taint.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
FIFO:
- Each entry stores `{A, A_t, B, B_t, v_t}`, where `v_t` is `in_valid_t` at push.
- Push when `in_valid && in_ready`.
- `in_ready = (count != DEPTH)`, combinational from registered `count`.
- Read/write pointers wrap modulo `DEPTH`.
- Pop happens only on the done event in WAIT.
- When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: `count` is unchanged.

Head outputs:
- `multiplier`, `multiplicand` and their taints come from the head entry.
- When the FIFO is empty, all four are 0.
- They stay stable from ISSUE through the pop.

FSM (registered state; `start = (state == ISSUE)`):
- IDLE: if `count != 0`, go to ISSUE.
- ISSUE: asserted for exactly one cycle, then go to WAIT unconditionally.
- WAIT: `done = productDone && !pd_q`, where `pd_q` is `productDone` registered every cycle.
  - On `done`: pop the head, go to IDLE.
  - Otherwise stay in WAIT, with no timeout.
- A `productDone` that is already high when WAIT is entered does not count; a fresh rising edge is required.

Taint:
- `ctrl_t` is a sticky bit. It is set on:
  - a push with `in_valid_t = 1`;
  - any WAIT cycle with `productDone_t = 1`;
  - any cycle with `pd_q_t = 1` while in WAIT.
- `pd_q_t` is `productDone_t` registered alongside `pd_q`.
- `ctrl_t` clears on `rst`, or at an edge where the state is IDLE and `count == 0` with no push that cycle.
- `in_ready_t = ctrl_t`.
- `busy_t = ctrl_t`.
- `start_t = start && (ctrl_t || head.v_t)`.
- Data taint is never ORed into control outputs.
- Operand taint passes through unchanged.

## Timing
- Reset values:
  - state IDLE;
  - `count` 0, pointers 0;
  - `start`, `start_t` 0;
  - operand outputs and their taints 0;
  - `in_ready` 1, `in_ready_t` 0;
  - `busy`, `busy_t` 0;
  - `pd_q`, `pd_q_t`, `ctrl_t` 0.
- Reset mid-operation discards all entries and in-flight issue; nothing pops. The multiplier is reset by the same `rst`.
- Latency from an empty, idle block: push accepted at edge k → `count` = 1 after k → state ISSUE after edge k+1. `start` is high for the cycle between edges k+1 and k+2.
- Done edge detected at edge d: pop at d, IDLE after d. If more entries remain, ISSUE after d+1. Minimum spacing between `start` pulses is therefore 3 cycles plus multiplier latency.
- `in_ready` rises the cycle after the pop that leaves the FIFO not full.

## Test plan
- Reset, then push one pair A=7, B=6 (untainted):
  - `start` is high exactly one cycle, 2 cycles after acceptance, with `multiplier`=7, `multiplicand`=6;
  - after the `productDone` rising edge: `count` 0, `busy` 0.
- Push 5 pairs back-to-back with `DEPTH`=4 and the multiplier stalled:
  - `in_ready` drops after the 4th push, and the 5th is held off;
  - after one done, the 5th is accepted;
  - pairs issue in FIFO order, with wrap-around verified.
- Hold `productDone` high across ISSUE into WAIT: no pop until it falls and rises again.
- Push a pair with `in_multiplier_t`=1 only: `multiplier_t`=1 while it is head; `start_t`=0, `in_ready_t`=0.
- Push with `in_valid_t`=1:
  - `start_t`=1 on its issue, and `in_ready_t`/`busy_t` are 1;
  - both clear once the block is idle and empty;
  - a subsequent clean pair issues with `start_t`=0.
- Assert `rst` during WAIT with 3 entries queued: next cycle `count` 0, state IDLE, all outputs at reset values, and no spurious `start`.
